arty_boot_ctrl: RTL and testbench

ARTY_BOOT_CTRL -- requirements
Module: arty_boot_ctrl

---
 rtl/arty_boot_ctrl.sv | 135 +++++++++++++
 tb/tb_arty_boot_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/arty_boot_ctrl.sv
// Boot/reset sequencer for the Arty SoC: synchronizes PLL lock and the soft-reset
// button, debounces the button, and steps the core through WAIT_LOCK/HOLD/LOAD/RUN.
module arty_boot_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       btn_rst,
  input  logic       boot_hold,
  input  logic       loader_done,
  output logic       core_rst_n,
  output logic       fetch_enable,
  output logic [1:0] state_o,
  output logic [7:0] boot_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    LOAD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);

  logic        pll_meta, pll_sync;
  logic        btn_meta, btn_sync;
  logic        btn_db, btn_db_q;
  logic [19:0] db_cnt;
  logic        press;

  state_t      state, state_next;
  logic [15:0] hold_cnt;
  logic        hold_done;
  logic        hold_clr;
  logic        boot_bump;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pll_meta <= 1'b0;
      pll_sync <= 1'b0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      pll_meta <= pll_locked;
      pll_sync <= pll_meta;
      btn_meta <= btn_rst;
      btn_sync <= btn_meta;
    end
  end

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_sync != btn_db) begin
        if (db_cnt == DB_LAST) begin
          btn_db <= btn_sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 20'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press     = btn_db & ~btn_db_q;
  assign hold_done = (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= WAIT_LOCK;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    hold_clr   = 1'b0;
    boot_bump  = 1'b0;
    if (!pll_sync) begin
      state_next = WAIT_LOCK;
    end else if (press && state != WAIT_LOCK) begin
      state_next = HOLD;
      hold_clr   = 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state_next = HOLD;
          hold_clr   = 1'b1;
        end
        HOLD: begin
          if (hold_done) begin
            state_next = boot_hold ? LOAD : RUN;
            boot_bump  = 1'b1;
          end
        end
        LOAD: begin
          if (loader_done || !boot_hold) state_next = RUN;
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (hold_clr) begin
      hold_cnt <= '0;
    end else if (state == HOLD && !hold_done) begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      boot_count <= '0;
    end else if (boot_bump && boot_count != 8'hFF) begin
      boot_count <= boot_count + 8'd1;
    end
  end

  assign core_rst_n   = (state == LOAD) || (state == RUN);
  assign fetch_enable = (state == RUN);
  assign state_o      = state;

endmodule

// File: tb/tb_arty_boot_ctrl.sv
// Scoreboard bench for arty_boot_ctrl: a behavioural model predicts outputs for each
// clock edge, a monitor compares them against the DUT one cycle at a time.
module tb_arty_boot_ctrl;

  localparam int HOLD_N = 16;
  localparam int DEB_N  = 4;

  typedef struct packed {
    logic [1:0] st;
    logic       crn;
    logic       fe;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       r_rst_n, r_pll, r_btn, r_bh, r_ld;
  logic       core_rst_n, fetch_enable;
  logic [1:0] state_o;
  logic [7:0] boot_count;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // model state
  int m_st, m_hold_left, m_cnt, m_run;
  bit m_db, m_press_pend;
  bit pll_h[$];
  bit btn_h[$];

  arty_boot_ctrl #(.RST_HOLD_CYCLES(HOLD_N), .DEBOUNCE_CYCLES(DEB_N)) dut (
    .clk(clk), .rst_n(r_rst_n), .pll_locked(r_pll), .btn_rst(r_btn),
    .boot_hold(r_bh), .loader_done(r_ld), .core_rst_n(core_rst_n),
    .fetch_enable(fetch_enable), .state_o(state_o), .boot_count(boot_count)
  );

  always #5 clk = ~clk;

  // Advance the model by one rising edge using the currently driven inputs.
  task automatic model_step();
    bit ps, bs, pr;
    exp_t e;
    if (!r_rst_n) begin
      m_st = 0; m_hold_left = 0; m_cnt = 0; m_run = 0;
      m_db = 0; m_press_pend = 0;
      pll_h = '{1'b0, 1'b0};
      btn_h = '{1'b0, 1'b0};
    end else begin
      ps = pll_h[0];
      bs = btn_h[0];
      pr = m_press_pend;
      if (!ps) begin
        m_st = 0;
      end else if (pr && m_st != 0) begin
        m_st = 1; m_hold_left = HOLD_N;
      end else if (m_st == 0) begin
        m_st = 1; m_hold_left = HOLD_N;
      end else if (m_st == 1) begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_st  = r_bh ? 2 : 3;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end else if (m_st == 2) begin
        if (r_ld || !r_bh) m_st = 3;
      end
      m_press_pend = 0;
      if (bs != m_db) begin
        m_run++;
        if (m_run == DEB_N) begin
          m_db = bs; m_run = 0; m_press_pend = bs;
        end
      end else begin
        m_run = 0;
      end
      void'(pll_h.pop_front()); pll_h.push_back(r_pll);
      void'(btn_h.pop_front()); btn_h.push_back(r_btn);
    end
    e.st  = 2'(m_st);
    e.crn = (m_st >= 2);
    e.fe  = (m_st == 3);
    e.cnt = 8'(m_cnt);
    sb.push_back(e);
  endtask

  // Called at a falling edge with inputs already set; predicts the next rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic pulse_ld();
    r_ld = 1'b1; tick(1); r_ld = 1'b0;
  endtask

  task automatic press_btn(input int len);
    r_btn = 1'b1; tick(len); r_btn = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (state_o !== e.st || core_rst_n !== e.crn || fetch_enable !== e.fe ||
            boot_count !== e.cnt) begin
          n_err++;
          $display("FAIL vec%0d t=%0t: got state=%0d core_rst_n=%b fetch_enable=%b boot_count=%0d, expected state=%0d core_rst_n=%b fetch_enable=%b boot_count=%0d",
                   n_vec, $time, state_o, core_rst_n, fetch_enable, boot_count,
                   e.st, e.crn, e.fe, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    r_rst_n = 1'b0; r_pll = 1'b1; r_btn = 1'b0; r_bh = 1'b0; r_ld = 1'b0;
    tick(4);

    // cold boot straight to RUN
    r_rst_n = 1'b1;
    tick(30);

    // loader boot via soft reset with boot_hold set
    r_bh = 1'b1;
    press_btn(6);
    tick(30);
    pulse_ld();
    tick(3);
    pulse_ld();
    tick(3);

    // glitch then real press
    press_btn(3);
    tick(10);
    r_bh = 1'b0;
    press_btn(6);
    tick(30);

    // lock loss in RUN, then relock
    r_pll = 1'b0; tick(5);
    r_pll = 1'b1; tick(30);

    // lock loss coinciding with a press
    r_btn = 1'b1; tick(4);
    r_pll = 1'b0; tick(2);
    r_btn = 1'b0; tick(6);
    r_pll = 1'b1; tick(30);

    // lock loss in HOLD
    press_btn(6);
    tick(6);
    r_pll = 1'b0; tick(3);
    r_pll = 1'b1; tick(25);

    // randomized operation
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) r_pll = 1'b0;
      else if (!r_pll && $urandom_range(0, 7) == 0) r_pll = 1'b1;
      if ($urandom_range(0, 5) == 0) r_btn = ~r_btn;
      if ($urandom_range(0, 49) == 0) r_bh = ~r_bh;
      r_ld    = ($urandom_range(0, 19) == 0);
      r_rst_n = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    r_rst_n = 1'b1; r_pll = 1'b1; r_btn = 1'b0; r_bh = 1'b0; r_ld = 1'b0;
    tick(40);

    // saturation of boot_count
    for (int k = 0; k < 260; k++) begin
      press_btn(6);
      tick(30);
    end

    // reset mid-HOLD
    press_btn(6);
    tick(6);
    r_rst_n = 1'b0; tick(2);
    r_rst_n = 1'b1; tick(30);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
